// File: rtl/tdc_meas_seq.sv
// TDC measurement sequencer: issues start pulses, times synchronized stop hits, streams results.
// Optional result accumulator enabled by defining TDC_MEAS_ACCUM_EN.
module tdc_meas_seq #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               ctl_start,
    input  logic               ctl_abort,
    input  logic [15:0]        ctl_num_meas,
    input  logic [CNT_W-1:0]   ctl_timeout,
    input  logic               stop_i,
    output logic               tdc_start_o,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [CNT_W:0]     result_data,
    output logic [15:0]        result_idx,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [15:0]        timeout_cnt,
    output logic [CNT_W+15:0]  accum_sum
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, STORE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t                 state;
    logic                   start_prev;
    logic [SYNC_STAGES-1:0] stop_sync;
    logic                   stop_prev;
    logic [CNT_W-1:0]       cnt;
    logic                   start_edge;
    logic                   stop_edge;
    logic                   accept_start;

    always_comb begin
        start_edge   = ctl_start & ~start_prev;
        stop_edge    = stop_sync[SYNC_STAGES-1] & ~stop_prev;
        accept_start = (state == IDLE) && start_edge && (ctl_num_meas != '0);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state        <= IDLE;
            start_prev   <= 1'b0;
            stop_sync    <= '0;
            stop_prev    <= 1'b0;
            cnt          <= '0;
            tdc_start_o  <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_idx   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            timeout_cnt  <= '0;
        end else begin
            start_prev  <= ctl_start;
            stop_sync   <= {stop_sync[SYNC_STAGES-2:0], stop_i};
            // Edge detector tracks continuously, so a level already high on RUN entry is not an edge.
            stop_prev   <= stop_sync[SYNC_STAGES-1];
            tdc_start_o <= 1'b0;

            if (state != IDLE && ctl_abort) begin
                state        <= IDLE;
                busy         <= 1'b0;
                result_valid <= 1'b0;
                aborted      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept_start) begin
                            state       <= ARM;
                            tdc_start_o <= 1'b1;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            aborted     <= 1'b0;
                            timeout_cnt <= '0;
                            result_idx  <= '0;
                        end
                    end
                    ARM: begin
                        cnt   <= '0;
                        state <= RUN;
                    end
                    RUN: begin
                        if (stop_edge) begin
                            result_data  <= {1'b0, cnt};
                            result_valid <= 1'b1;
                            state        <= STORE;
                        end else if (cnt == ctl_timeout) begin
                            result_data  <= {1'b1, cnt};
                            result_valid <= 1'b1;
                            if (timeout_cnt != 16'hFFFF)
                                timeout_cnt <= timeout_cnt + 16'd1;
                            state        <= STORE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    STORE: begin
                        if (result_ready) begin
                            result_valid <= 1'b0;
                            result_idx   <= result_idx + 16'd1;
                            if (result_idx + 16'd1 == ctl_num_meas) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state       <= ARM;
                                tdc_start_o <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef TDC_MEAS_ACCUM_EN
    logic accept_result;

    always_comb begin
        accept_result = (state == STORE) && !ctl_abort && result_ready && !result_data[CNT_W];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            accum_sum <= '0;
        else if (accept_start)
            accum_sum <= '0;
        else if (accept_result)
            accum_sum <= accum_sum + {16'b0, result_data[CNT_W-1:0]};
    end
`else
    assign accum_sum = '0;
`endif

endmodule

// File: tb/tb_tdc_meas_seq.sv
// Directed self-checking bench for tdc_meas_seq (checks accum_sum according to TDC_MEAS_ACCUM_EN).
module tb_tdc_meas_seq;
    localparam int CNT_W = 16;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              ctl_start = 1'b0;
    logic              ctl_abort = 1'b0;
    logic [15:0]       ctl_num_meas = '0;
    logic [CNT_W-1:0]  ctl_timeout = '0;
    logic              stop_i = 1'b0;
    logic              result_ready = 1'b0;
    logic              tdc_start_o;
    logic              result_valid;
    logic [CNT_W:0]    result_data;
    logic [15:0]       result_idx;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [15:0]       timeout_cnt;
    logic [CNT_W+15:0] accum_sum;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;
    int k;

    always #5 ACLK = ~ACLK;

    tdc_meas_seq #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .ctl_start(ctl_start), .ctl_abort(ctl_abort),
        .ctl_num_meas(ctl_num_meas), .ctl_timeout(ctl_timeout), .stop_i(stop_i),
        .tdc_start_o(tdc_start_o), .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_idx(result_idx), .busy(busy), .done(done),
        .aborted(aborted), .timeout_cnt(timeout_cnt), .accum_sum(accum_sum)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200 && result_valid !== 1'b1; i++) tick();
        check("wait_valid", 64'(result_valid), 64'd1);
    endtask

    task automatic pulse_start();
        ctl_start = 1'b1;
        tick();
        ctl_start = 1'b0;
    endtask

    // Called with ARM visible; stop_i goes high so it is first sampled at the end of cycle s.
    task automatic run_stop(input int s, input logic [CNT_W:0] exp, input string tag);
        repeat (s) tick();
        stop_i = 1'b1;
        wait_valid();
        check(tag, 64'(result_data), 64'(exp));
        stop_i = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_tdc_start", 64'(tdc_start_o), 0);
        check("rst_valid", 64'(result_valid), 0);
        check("rst_data", 64'(result_data), 0);
        check("rst_idx", 64'(result_idx), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_aborted", 64'(aborted), 0);
        check("rst_tocnt", 64'(timeout_cnt), 0);
        check("rst_accum", 64'(accum_sum), 0);
        ARESET = 1'b0;
        tick();

        // Single measurement, stop at s=10
        ctl_num_meas = 16'd1; ctl_timeout = 16'd100; result_ready = 1'b1;
        pulse_start();
        check("t1_start_pulse", 64'(tdc_start_o), 1);
        check("t1_busy", 64'(busy), 1);
        run_stop(10, 17'd11, "t1_data");
        check("t1_idx", 64'(result_idx), 0);
        tick();
        check("t1_done", 64'(done), 1);
        check("t1_busy_end", 64'(busy), 0);
        check("t1_tocnt", 64'(timeout_cnt), 0);
        check("t1_valid_end", 64'(result_valid), 0);

        // Three timeouts
        ctl_num_meas = 16'd3; ctl_timeout = 16'd5;
        pulse_start();
        check("t2_done_cleared", 64'(done), 0);
        pulses = tdc_start_o ? 1 : 0;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            if (result_valid) begin
                check("t2_data", 64'(result_data), 64'h10005);
                check("t2_idx", 64'(result_idx), 64'(k));
                k++;
            end
            tick();
            if (tdc_start_o) pulses++;
            if (!busy) break;
        end
        check("t2_results", 64'(k), 3);
        check("t2_pulses", 64'(pulses), 3);
        check("t2_tocnt", 64'(timeout_cnt), 3);
        check("t2_done", 64'(done), 1);

        // Back-pressure: ready low for 20 cycles
        ctl_num_meas = 16'd1; ctl_timeout = 16'd3; result_ready = 1'b0;
        pulse_start();
        wait_valid();
        check("t3_data", 64'(result_data), 64'h10003);
        repeat (20) begin
            tick();
            check("t3_hold_valid", 64'(result_valid), 1);
            check("t3_hold_data", 64'(result_data), 64'h10003);
            check("t3_hold_idx", 64'(result_idx), 0);
            check("t3_no_start", 64'(tdc_start_o), 0);
        end
        result_ready = 1'b1;
        tick();
        check("t3_valid_end", 64'(result_valid), 0);
        check("t3_done", 64'(done), 1);

        // Abort in RUN of 2nd of 4
        ctl_num_meas = 16'd4; ctl_timeout = 16'd50;
        pulse_start();
        wait_valid();
        tick();
        check("t4_second_arm", 64'(tdc_start_o), 1);
        check("t4_idx1", 64'(result_idx), 1);
        tick(); tick();
        ctl_abort = 1'b1;
        tick();
        ctl_abort = 1'b0;
        check("t4_busy", 64'(busy), 0);
        check("t4_aborted", 64'(aborted), 1);
        check("t4_done", 64'(done), 0);
        check("t4_valid", 64'(result_valid), 0);
        check("t4_tdc_start", 64'(tdc_start_o), 0);
        check("t4_tocnt", 64'(timeout_cnt), 1);
        repeat (3) tick();
        check("t4_stay_idle", 64'(busy), 0);
        pulse_start();
        check("t4_restart_aborted", 64'(aborted), 0);
        check("t4_restart_idx", 64'(result_idx), 0);
        check("t4_restart_tocnt", 64'(timeout_cnt), 0);
        check("t4_restart_pulse", 64'(tdc_start_o), 1);
        ctl_abort = 1'b1;
        tick();
        ctl_abort = 1'b0;
        check("t4_abort_arm", 64'(busy), 0);

        // Abort in STORE with ready high discards the result
        ctl_num_meas = 16'd2; ctl_timeout = 16'd2;
        pulse_start();
        wait_valid();
        ctl_abort = 1'b1;
        tick();
        ctl_abort = 1'b0;
        check("t4b_idx", 64'(result_idx), 0);
        check("t4b_valid", 64'(result_valid), 0);
        check("t4b_busy", 64'(busy), 0);
        check("t4b_aborted", 64'(aborted), 1);
        check("t4b_done", 64'(done), 0);

        // Ignored starts
        ctl_num_meas = 16'd0;
        pulse_start();
        check("t5_zero_busy", 64'(busy), 0);
        check("t5_zero_pulse", 64'(tdc_start_o), 0);
        check("t5_zero_aborted", 64'(aborted), 1);
        tick();
        check("t5_zero_busy2", 64'(busy), 0);
        ctl_num_meas = 16'd1; ctl_timeout = 16'd20;
        pulse_start();
        tick(); tick();
        pulse_start();
        check("t5_busy_edge_pulse", 64'(tdc_start_o), 0);
        check("t5_busy_edge_busy", 64'(busy), 1);
        wait_valid();
        check("t5_data", 64'(result_data), 64'h10014);
        tick();
        check("t5_done", 64'(done), 1);
        check("t5_tocnt", 64'(timeout_cnt), 1);

        // Accumulator: 11, timeout, 7
        ctl_num_meas = 16'd3; ctl_timeout = 16'd30;
        pulse_start();
        run_stop(10, 17'd11, "t6_m0");
        tick();
        check("t6_arm1", 64'(tdc_start_o), 1);
        wait_valid();
        check("t6_m1", 64'(result_data), 64'h1001E);
        tick();
        check("t6_arm2", 64'(tdc_start_o), 1);
        run_stop(6, 17'd7, "t6_m2");
        tick();
        check("t6_done", 64'(done), 1);
`ifdef TDC_MEAS_ACCUM_EN
        check("t6_accum", 64'(accum_sum), 18);
`else
        check("t6_accum", 64'(accum_sum), 0);
`endif

        // Reset mid-run
        ctl_num_meas = 16'd2; ctl_timeout = 16'd40;
        pulse_start();
        repeat (5) tick();
        ARESET = 1'b1;
        #1;
        check("t7_busy", 64'(busy), 0);
        check("t7_done", 64'(done), 0);
        check("t7_accum", 64'(accum_sum), 0);
        check("t7_idx", 64'(result_idx), 0);
        ARESET = 1'b0;
        tick();
        check("t7_idle", 64'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
